// File: rtl/axil_lockstep_pkg.sv
// axil_lockstep_pkg: group indices and field layout helpers for the lockstep monitor vector
package axil_lockstep_pkg;
  localparam int NGROUP = 11;
  localparam int G_S_AWREADY = 0;
  localparam int G_S_WREADY = 1;
  localparam int G_S_BRESP = 2;
  localparam int G_S_BVALID = 3;
  localparam int G_M_AWADDR = 4;
  localparam int G_M_AWPROT = 5;
  localparam int G_M_AWVALID = 6;
  localparam int G_M_WDATA = 7;
  localparam int G_M_WSTRB = 8;
  localparam int G_M_WVALID = 9;
  localparam int G_M_BREADY = 10;

  function automatic int vec_w(int s, int m, int dw, int aw, int sw);
    return s * 5 + m * (aw + dw + sw + 6);
  endfunction

  function automatic int grp_width(int g, int s, int m, int dw, int aw, int sw);
    case (g)
      G_S_AWREADY, G_S_WREADY, G_S_BVALID: return s;
      G_S_BRESP: return 2 * s;
      G_M_AWADDR: return m * aw;
      G_M_AWPROT: return 3 * m;
      G_M_WDATA: return m * dw;
      G_M_WSTRB: return m * sw;
      default: return m;
    endcase
  endfunction

  function automatic int grp_off(int g, int s, int m, int dw, int aw, int sw);
    int o;
    o = 0;
    for (int i = 0; i < g; i++) o += grp_width(i, s, m, dw, aw, sw);
    return o;
  endfunction

  // Valid group that qualifies a payload group's lanes, or -1 when always compared
  function automatic int qual_group(int g);
    return g == G_S_BRESP ? G_S_BVALID :
           (g == G_M_AWADDR || g == G_M_AWPROT) ? G_M_AWVALID :
           (g == G_M_WDATA || g == G_M_WSTRB) ? G_M_WVALID : -1;
  endfunction
endpackage

// File: rtl/axil_lockstep_delay.sv
// axil_lockstep_delay: WIDTH x DEPTH shift register with per-stage valid tag
module axil_lockstep_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);
  if (DEPTH == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk;
    assign q = d;
    assign q_valid = !rst;
  end else begin : g_pipe
    logic [WIDTH-1:0] sr [DEPTH];
    logic [DEPTH-1:0] tag;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        tag <= '0;
      end else begin
        sr[0] <= d;
        tag[0] <= 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
          sr[i] <= sr[i-1];
          tag[i] <= tag[i-1];
        end
      end
    assign q = sr[DEPTH-1];
    assign q_valid = tag[DEPTH-1];
  end
endmodule

// File: rtl/axil_wr_lockstep_monitor.sv
// axil_wr_lockstep_monitor: compares two AXI-lite write crossbar instances with lag and valid qualification
module axil_wr_lockstep_monitor
  import axil_lockstep_pkg::*;
#(
  parameter int               S_COUNT     = 4,
  parameter int               M_COUNT     = 4,
  parameter int               DATA_WIDTH  = 32,
  parameter int               ADDR_WIDTH  = 32,
  parameter int               STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int               LAG         = 0,
  parameter bit               QUALIFY     = 1'b1,
  parameter logic [NGROUP-1:0] GROUP_MASK = 11'h7FF,
  parameter int               COUNT_WIDTH = 16,
  parameter int               CYC_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [vec_w(S_COUNT, M_COUNT, DATA_WIDTH, ADDR_WIDTH, STRB_WIDTH)-1:0] a_vec,
  input  logic [vec_w(S_COUNT, M_COUNT, DATA_WIDTH, ADDR_WIDTH, STRB_WIDTH)-1:0] b_vec,
  output logic                   mismatch,
  output logic                   err_sticky,
  output logic [NGROUP-1:0]      err_group,
  output logic [COUNT_WIDTH-1:0] mismatch_count,
  output logic [CYC_WIDTH-1:0]   first_cycle,
  output logic [NGROUP-1:0]      first_group
);
  localparam int VEC_W = vec_w(S_COUNT, M_COUNT, DATA_WIDTH, ADDR_WIDTH, STRB_WIDTH);

  function automatic int off(int g);
    return grp_off(g, S_COUNT, M_COUNT, DATA_WIDTH, ADDR_WIDTH, STRB_WIDTH);
  endfunction

  logic [VEC_W-1:0]     ad;
  logic                 tag;
  logic [NGROUP-1:0]    gdiff;
  logic                 hit;
  logic [CYC_WIDTH-1:0] cyc;

  axil_lockstep_delay #(.WIDTH(VEC_W), .DEPTH(LAG)) u_delay (
    .clk     (clk),
    .rst     (rst),
    .d       (a_vec),
    .q       (ad),
    .q_valid (tag)
  );

  // Lane-wise compare; payload lanes are gated by the delayed A-side valid of the same lane
  for (genvar g = 0; g < NGROUP; g++) begin : grp
    localparam int NL = g < G_M_AWADDR ? S_COUNT : M_COUNT;
    localparam int LW = grp_width(g, S_COUNT, M_COUNT, DATA_WIDTH, ADDR_WIDTH, STRB_WIDTH) / NL;
    localparam int O = off(g);
    localparam int Q = qual_group(g);
    logic [NL-1:0] ne;
    for (genvar l = 0; l < NL; l++) begin : lane
      if (QUALIFY && Q >= 0) begin : q
        assign ne[l] = ad[off(Q)+l] && (ad[O+l*LW +: LW] != b_vec[O+l*LW +: LW]);
      end else begin : u
        assign ne[l] = ad[O+l*LW +: LW] != b_vec[O+l*LW +: LW];
      end
    end
    assign gdiff[g] = GROUP_MASK[g] && (|ne);
  end

  assign hit = enable && tag && (|gdiff);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cyc <= '0;
      mismatch <= 1'b0;
      err_sticky <= 1'b0;
      err_group <= '0;
      mismatch_count <= '0;
      first_cycle <= '0;
      first_group <= '0;
    end else begin
      cyc <= cyc + 1'b1;
      mismatch <= hit;
      if (clear) begin
        err_sticky <= 1'b0;
        err_group <= '0;
        mismatch_count <= '0;
        first_cycle <= '0;
        first_group <= '0;
      end else if (hit) begin
        err_sticky <= 1'b1;
        err_group <= err_group | gdiff;
        mismatch_count <= (&mismatch_count) ? mismatch_count : mismatch_count + 1'b1;
        if (!err_sticky) begin
          first_cycle <= cyc;
          first_group <= gdiff;
        end
      end
    end
endmodule

// File: tb/tb_axil_wr_lockstep_monitor.sv
// tb_axil_wr_lockstep_monitor: directed checks of lag, qualification, clear, saturation and reset
module tb_axil_wr_lockstep_monitor;
  localparam int VW = 316;
  localparam int B_AWADDR2 = 84;
  localparam int B_AWVALID2 = 162;
  localparam int B_WDATA0 = 164;
  localparam int B_WVALID0 = 308;
  localparam int B_BREADY0 = 312;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en0, en1, en2, en3, clr0;
  logic [VW-1:0] a0, b0, a3, b3;
  logic [VW-1:0] hist [128];
  int n_chk = 0;
  int n_fail = 0;

  logic m0, m1, m2, m3, es0, es1, es2, es3;
  logic [10:0] eg0, eg1, eg2, eg3, fg0, fg1, fg2, fg3;
  logic [15:0] mc0, mc1, mc3;
  logic [1:0] mc2;
  logic [31:0] fc0, fc1, fc2, fc3;

  always #5 clk = ~clk;

  axil_wr_lockstep_monitor dut0 (.clk(clk), .rst(rst), .enable(en0), .clear(clr0), .a_vec(a0), .b_vec(b0),
    .mismatch(m0), .err_sticky(es0), .err_group(eg0), .mismatch_count(mc0), .first_cycle(fc0), .first_group(fg0));
  axil_wr_lockstep_monitor #(.QUALIFY(1'b0)) dut1 (.clk(clk), .rst(rst), .enable(en1), .clear(1'b0), .a_vec(a0), .b_vec(b0),
    .mismatch(m1), .err_sticky(es1), .err_group(eg1), .mismatch_count(mc1), .first_cycle(fc1), .first_group(fg1));
  axil_wr_lockstep_monitor #(.COUNT_WIDTH(2)) dut2 (.clk(clk), .rst(rst), .enable(en2), .clear(1'b0), .a_vec(a0), .b_vec(b0),
    .mismatch(m2), .err_sticky(es2), .err_group(eg2), .mismatch_count(mc2), .first_cycle(fc2), .first_group(fg2));
  axil_wr_lockstep_monitor #(.LAG(3)) dut3 (.clk(clk), .rst(rst), .enable(en3), .clear(1'b0), .a_vec(a3), .b_vec(b3),
    .mismatch(m3), .err_sticky(es3), .err_group(eg3), .mismatch_count(mc3), .first_cycle(fc3), .first_group(fg3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rnd();
    logic [319:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[VW-1:0];
  endfunction

  task tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    en0 = 1'b1; en1 = 1'b0; en2 = 1'b0; en3 = 1'b1; clr0 = 1'b0;
    a0 = '0; b0 = '0; a3 = '0; b3 = '0;
    #1;
    chk("rst_mismatch", m0, 0);
    chk("rst_sticky", es0, 0);
    chk("rst_group", eg0, 0);
    chk("rst_count", mc0, 0);
    chk("rst_first_cycle", fc0, 0);
    chk("rst_first_group", fg0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      a0 = rnd(); b0 = a0;
      tick;
      chk("ident_nomatch", m0, 0);
    end
    a0 = rnd(); a0[B_AWVALID2] = 1'b1; b0 = a0; b0[B_AWADDR2] = ~b0[B_AWADDR2];
    tick;
    chk("awaddr_pulse", m0, 1);
    chk("awaddr_first_cycle", fc0, 10);
    chk("awaddr_first_group", fg0, 11'h010);
    chk("awaddr_count", mc0, 1);
    chk("awaddr_sticky", es0, 1);
    chk("awaddr_err_group", eg0, 11'h010);
    b0 = a0;
    tick;
    chk("pulse_drops", m0, 0);
    chk("count_holds", mc0, 1);
    a0 = rnd(); a0[B_WVALID0] = 1'b0; b0 = a0; b0[B_WDATA0] = ~b0[B_WDATA0]; en1 = 1'b1;
    tick;
    chk("qual_wdata_masked", m0, 0);
    chk("qual_count_holds", mc0, 1);
    chk("noqual_pulse", m1, 1);
    chk("noqual_first_group", fg1, 11'h080);
    chk("noqual_first_cycle", fc1, 12);
    a0[B_WVALID0] = 1'b1; b0 = a0; b0[B_WDATA0] = ~b0[B_WDATA0];
    tick;
    chk("qual_wdata_valid", m0, 1);
    chk("qual_err_group", eg0, 11'h090);
    chk("qual_count", mc0, 2);
    chk("first_cycle_kept", fc0, 10);
    chk("noqual_count", mc1, 2);
    b0 = a0; clr0 = 1'b1;
    tick;
    clr0 = 1'b0;
    chk("clr_sticky", es0, 0);
    chk("clr_group", eg0, 0);
    chk("clr_count", mc0, 0);
    chk("clr_first_cycle", fc0, 0);
    chk("clr_first_group", fg0, 0);
    en2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a0 = rnd(); b0 = a0; b0[B_BREADY0] = ~b0[B_BREADY0]; clr0 = (k == 3);
      tick;
      chk("consec_pulse", m0, 1);
      chk("consec_count", mc0, k < 3 ? k + 1 : 0);
    end
    clr0 = 1'b0;
    chk("clr_drop_sticky", es0, 0);
    a0 = rnd(); b0 = a0; b0[B_BREADY0] = ~b0[B_BREADY0];
    tick;
    en2 = 1'b0;
    chk("after_clr_count", mc0, 1);
    chk("after_clr_first_cycle", fc0, 19);
    chk("after_clr_first_group", fg0, 11'h400);
    chk("after_clr_sticky", es0, 1);
    chk("sat_count", mc2, 3);
    en0 = 1'b0;
    tick;
    chk("enable_gate_pulse", m0, 0);
    chk("enable_gate_count", mc0, 1);
    en0 = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_sat_count", mc2, 0);
    chk("midrst_sticky", es0, 0);
    chk("midrst_first_cycle", fc0, 0);
    chk("midrst_count1", mc1, 0);
    chk("midrst_group1", eg1, 0);
    tick;
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      a3 = rnd(); hist[c] = a3;
      if (c < 3) b3 = ~a3;
      else b3 = hist[c-3];
      a0 = a3; b0 = a3;
      tick;
      chk("lag_nomatch", m3, 0);
    end
    chk("lag_sticky", es3, 0);
    chk("ident100_sticky", es0, 0);
    a3 = rnd(); b3 = hist[97]; b3[B_BREADY0] = ~b3[B_BREADY0];
    tick;
    chk("lag_pulse", m3, 1);
    chk("lag_first_cycle", fc3, 100);
    chk("lag_first_group", fg3, 11'h400);
    chk("lag_count", mc3, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_wr_lockstep_monitor.md
# axil_wr_lockstep_monitor

Synthesizable lockstep monitor for the AXI-lite write crossbar. It compares every output of two crossbar write-path instances, A (golden) and B (candidate), cycle by cycle. B may lag A by a fixed number of cycles, and payload comparison can be qualified by the valid bits. Mismatch events are counted, the first one is captured, and sticky per-group flags are kept, so equivalence checking runs in hardware and in long simulations, not only under formal.

## Interface
- S_COUNT, 4, crossbar slave interfaces
- M_COUNT, 4, crossbar master interfaces
- DATA_WIDTH, 32, data bus bits
- ADDR_WIDTH, 32, address bits
- STRB_WIDTH, DATA_WIDTH/8, strobe bits
- LAG, 0, cycles B lags A (0..15)
- QUALIFY, 1, compare payload lanes only when their A-side valid is 1
- GROUP_MASK, 11'h7FF, per-group compare enable
- COUNT_WIDTH, 16, mismatch counter bits
- CYC_WIDTH, 32, cycle stamp bits
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  comparison enable
- clear  input  1  synchronous clear of all status
- a_vec  input  VEC_W  instance A outputs, packed per package layout
- b_vec  input  VEC_W  instance B outputs, same layout
- mismatch  output  1  registered one-cycle pulse per mismatching aligned sample
- err_sticky  output  1  any mismatch since reset or clear
- err_group  output  11  sticky per-group mismatch flags
- mismatch_count  output  COUNT_WIDTH  saturating count of mismatching samples
- first_cycle  output  CYC_WIDTH  cycle stamp of first mismatch
- first_group  output  11  groups differing in first mismatch

## Operation
- Groups, in index order: 0 s_awready, 1 s_wready, 2 s_bresp, 3 s_bvalid, 4 m_awaddr, 5 m_awprot, 6 m_awvalid, 7 m_wdata, 8 m_wstrb, 9 m_wvalid, 10 m_bready.
- VEC_W = S_COUNT*5 + M_COUNT*(ADDR_WIDTH+DATA_WIDTH+STRB_WIDTH+6). Groups are packed ascending from bit 0; lanes within a group are packed ascending.
- A passes through a LAG-deep delay line. A valid-tag shift register, zeroed on reset, marks which stages hold real samples. Comparison is allowed only when the tag of the aligned sample is 1, so the first LAG cycles after reset never flag.
- Per-lane qualification when QUALIFY=1:
  - bresp lane i is compared only if delayed A s_bvalid[i] is 1.
  - awaddr and awprot lane j are compared only if delayed A m_awvalid[j] is 1.
  - wdata and wstrb lane j are compared only if delayed A m_wvalid[j] is 1.
  - valid and ready groups are always compared.
- Group g differs when any compared lane differs and GROUP_MASK[g] is 1. A sample mismatches when any group differs, enable is 1 and the tag is 1.
- Free-running cycle counter cyc: reset 0, increments every cycle, wraps at 2^CYC_WIDTH.
- On a mismatch:
  - mismatch pulses.
  - err_group ORs in the differing groups.
  - mismatch_count increments and saturates at all-ones.
  - If err_sticky was 0: first_cycle takes the cyc value of the B sample and first_group takes the differing set; then err_sticky is set to 1.
- clear zeroes err_sticky, err_group, mismatch_count, first_cycle and first_group. clear has priority: a mismatch in the same cycle is dropped, though mismatch still pulses. clear does not touch the delay line or cyc.
- enable=0 gates comparison only; the delay line and cyc keep running.

## Timing
- All outputs reset to 0; reset asynchronously forces the delay line, tags, cyc and all status to 0.
- With B sampled at cycle t (A at t-LAG), mismatch and updated status are visible at cycle t+1, one register stage after the compare.
- Consecutive mismatching samples give consecutive mismatch pulses, and the count increments once per cycle.
- Reset asserted mid-run drops all pending delayed samples; warm-up restarts for LAG cycles after deassertion.
- LAG=0: no delay line, A and B are compared in the same cycle, and the tag is always 1 after reset.

## Structure
- Package axil_lockstep_pkg holds:
  - group index constants and NGROUP=11;
  - functions for VEC_W and for each group's field offset and width given S_COUNT, M_COUNT, DATA_WIDTH, ADDR_WIDTH, STRB_WIDTH.
- Sub-module axil_lockstep_delay: parametrised WIDTH x DEPTH shift register with a valid tag and asynchronous reset; it passes input straight through when DEPTH=0.

## Test plan
- LAG=0, identical vectors for 100 cycles -> mismatch never 1, all status 0.
- LAG=0, B m_awaddr lane 2 differs at cyc 10 with A m_awvalid[2]=1 -> mismatch at cyc 11, first_cycle=10, first_group=11'h010, count=1.
- QUALIFY=1, B m_wdata lane 0 differs while A m_wvalid[0]=0 -> no flag; with QUALIFY=0 the same stimulus flags group 7.
- LAG=3, B equal to A delayed by 3, A randomised -> no flag; during cycles 0..2 after reset B differs -> no flag.
- Mismatches on 3 consecutive cycles, then clear pulsed in the same cycle as a 4th mismatch -> count goes 1,2,3 then 0 and err_sticky=0; the next mismatch sets first_cycle to that cycle.
- COUNT_WIDTH=2, 5 mismatches -> count saturates at 3; rst pulsed mid-run -> all outputs 0 immediately.
